// File: rtl/fifo_tx_scheduler.sv
// Pops bytes from the synchronous TX FIFO one at a time and hands each one to the UART shifter.
// Enforces an inter-frame gap, counts completed frames and flags handshake timeouts.
module fifo_tx_scheduler #(
  parameter int DSIZE       = 8,
  parameter int GAP_CYCLES  = 2,
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             fifo_empty,
  output logic             fifo_ren,
  input  logic [DSIZE-1:0] fifo_rdata,
  output logic             tx_start,
  output logic [DSIZE-1:0] tx_data,
  input  logic             tx_busy,
  output logic             active,
  output logic [CNT_W-1:0] byte_count,
  output logic             timeout_err,
  input  logic             clr_err,
  output logic [2:0]       state_o
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 2);
  localparam logic [TW-1:0] T_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_READ      = 3'd1,
    S_CAPTURE   = 3'd2,
    S_START     = 3'd3,
    S_WAIT_ACK  = 3'd4,
    S_WAIT_DONE = 3'd5,
    S_GAP       = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [DSIZE-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      tmo_q   <= '0;
      gap_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Handshake: tx_start is a one-cycle request; the shifter accepts by raising tx_busy
  // and finishes by dropping it. tx_data stays stable across the whole request/busy window.
  always_comb begin
    state_d  = state_q;
    tmo_d    = tmo_q;
    gap_d    = gap_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    err_d    = err_q & ~clr_err;
    fifo_ren = 1'b0;
    tx_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable && !fifo_empty) state_d = S_READ;
      end
      S_READ: begin
        fifo_ren = 1'b1;
        state_d  = S_CAPTURE;
      end
      S_CAPTURE: begin
        data_d  = fifo_rdata;
        state_d = S_START;
      end
      S_START: begin
        tx_start = 1'b1;
        tmo_d    = '0;
        state_d  = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (tmo_q == T_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          cnt_d   = cnt_q + 1'b1;
          gap_d   = '0;
          state_d = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_q == G_LAST) state_d = S_IDLE;
        else                 gap_d   = gap_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign active      = (state_q != S_IDLE);
  assign tx_data     = data_q;
  assign byte_count  = cnt_q;
  assign timeout_err = err_q;
  assign state_o     = state_q;

endmodule

// File: doc/fifo_tx_scheduler.md
Name: fifo_tx_scheduler

Overview:
- Sequences the synchronous byte FIFO into the UART transmitter.
- Pops one byte at a time and absorbs the FIFO's one-cycle registered read latency.
- Hands each byte to the transmitter with a start/busy handshake, enforces a minimum inter-frame gap, and reports progress and errors.
- Sits between the TX FIFO read port and the UART TX shifter.

Parameters:
- DSIZE, 8, data width of the FIFO read data and of tx_data.
- GAP_CYCLES, 2, idle cycles inserted after each frame completes; 0 means no gap.
- ACK_TIMEOUT, 16, maximum cycles to wait for tx_busy to rise after tx_start; must be at least 1.
- CNT_W, 16, width of the transmitted-byte counter.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  permits new pops; sampled only in IDLE.
- fifo_empty  input  1  FIFO empty flag.
- fifo_ren  output  1  FIFO read enable, high for one cycle per pop.
- fifo_rdata  input  DSIZE  FIFO read data; valid in the cycle after fifo_ren.
- tx_start  output  1  one-cycle pulse requesting a frame.
- tx_data  output  DSIZE  byte to transmit; held stable from tx_start until tx_busy falls.
- tx_busy  input  1  transmitter is shifting a frame.
- active  output  1  high in every state except IDLE.
- byte_count  output  CNT_W  frames completed since reset.
- timeout_err  output  1  sticky flag; set on handshake timeout.
- clr_err  input  1  clears timeout_err.

Behaviour:
- Reset is synchronous and active-high. All outputs are 0, state goes to IDLE, and the gap and timeout counters clear.
- Reset asserted mid-operation aborts immediately. Any byte already popped is discarded; no replay.
- States: IDLE, READ, CAPTURE, START, WAIT_ACK, WAIT_DONE, GAP.
- IDLE:
  - enable=1 and fifo_empty=0 -> READ.
  - Otherwise stay. fifo_ren=0.
- READ: fifo_ren=1 for exactly this cycle -> CAPTURE. The FIFO registers the data and advances its read pointer on this edge.
- CAPTURE: tx_data <= fifo_rdata on the clock edge -> START. Capture happens only here; fifo_rdata is 0 in any cycle not following a read.
- START: tx_start=1 for one cycle; the timeout counter loads 0 -> WAIT_ACK.
- WAIT_ACK:
  - tx_busy=1 -> WAIT_DONE.
  - Otherwise the counter increments; when it reaches ACK_TIMEOUT-1 with tx_busy still 0: timeout_err <= 1, go to IDLE, byte_count unchanged.
- WAIT_DONE:
  - tx_busy=0 -> byte_count increments by 1, modulo 2^CNT_W (wraps to 0).
  - Then GAP if GAP_CYCLES > 0, otherwise IDLE.
- GAP: stay exactly GAP_CYCLES cycles -> IDLE.
- Latency: IDLE decision to tx_start is 3 cycles. READ and START occur 2 cycles apart.
- Minimum frame-to-frame fifo_ren spacing is 1 cycle (START) + frame length + GAP_CYCLES + 3 cycles.
- enable deasserted outside IDLE: the current byte completes normally; no new pop happens afterwards.
- fifo_empty is ignored outside IDLE. Only this block reads the FIFO, so empty cannot rise between the IDLE decision and READ.
- tx_data holds its last value in IDLE.
- clr_err=1 clears timeout_err. If a timeout and clr_err occur in the same cycle, set wins.
- Only one pop is ever outstanding; fifo_ren never asserts while fifo_empty=1 in the same cycle.

Test Plan:
- Single byte: reset, FIFO holds 0xA5, enable=1, tx_busy high 3 cycles after tx_start, then low 10 cycles later.
  -> fifo_ren one cycle, tx_start 2 cycles later with tx_data=0xA5.
  -> byte_count=1, then 2 GAP cycles, then IDLE with active=0.
- Burst of 4 bytes (0x01..0x04) with back-to-back availability.
  -> 4 pops in order, 4 tx_start pulses with matching tx_data, byte_count=4.
  -> Each pop is separated by at least GAP_CYCLES+frame+4 cycles; the FIFO ends empty.
- Timeout: tx_busy held 0 after tx_start.
  -> timeout_err=1 after 16 cycles in WAIT_ACK; IDLE; byte_count unchanged.
  -> clr_err pulse -> timeout_err=0.
- Disable mid-frame: enable drops during WAIT_DONE with 3 bytes queued.
  -> The current byte completes, byte_count increments once, and there is no further fifo_ren while enable=0.
- Reset mid-operation: reset asserted during WAIT_DONE.
  -> Next cycle all outputs are 0 and state is IDLE. After release, the next queued byte is popped normally.
- Counter wrap: with CNT_W=4, send 17 bytes.
  -> byte_count goes 15 -> 0 -> 1; final value 1.
